// File: rtl/column_frame_strobe_ctrl.sv
// rtl/column_frame_strobe_ctrl.sv - per-column one-hot FrameStrobe generator
module column_frame_strobe_ctrl #(
    parameter int FrameBitsPerRow  = 32,
    parameter int MaxFramesPerCol  = 20,
    parameter int ColSelectWidth   = 5,
    parameter int FrameSelectWidth = 5,
    parameter int Col              = 0,
    parameter int StrobeWidth      = 2,
    parameter int GapCycles        = 1
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic [FrameBitsPerRow-1:0] FrameAddressRegister,
    input  logic                       FrameAddressValid,
    output logic                       FrameAddressReady,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       Busy,
    output logic                       ErrFrameIdx,
    input  logic                       ErrClear
);

    localparam int CntMax = (StrobeWidth > GapCycles) ? StrobeWidth : GapCycles;
    localparam int CntW   = $clog2(CntMax) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t                      state;
    logic [CntW-1:0]             cnt;
    logic [ColSelectWidth-1:0]   colField;
    logic [FrameSelectWidth-1:0] frameField;
    logic                        accept;
    logic                        colMatch;
    logic                        frameOk;
    logic                        unusedAddrBits;

    assign colField   = FrameAddressRegister[FrameBitsPerRow-1 -: ColSelectWidth];
    assign frameField = FrameAddressRegister[FrameSelectWidth-1:0];
    // Bits between the column and frame fields carry no meaning for this column.
    assign unusedAddrBits = ^FrameAddressRegister[FrameBitsPerRow-ColSelectWidth-1:FrameSelectWidth];

    assign FrameAddressReady = (state == IDLE) && !Reset;
    assign accept            = FrameAddressValid && FrameAddressReady;
    assign colMatch          = (colField == ColSelectWidth'(Col));
    assign frameOk           = (32'(frameField) < 32'(MaxFramesPerCol));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            FrameStrobe <= '0;
            Busy        <= 1'b0;
            ErrFrameIdx <= 1'b0;
        end else begin
            // A bad index on a matching word wins over a simultaneous clear.
            if (accept && colMatch && !frameOk)
                ErrFrameIdx <= 1'b1;
            else if (ErrClear)
                ErrFrameIdx <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept && colMatch && frameOk) begin
                        state       <= STROBE;
                        Busy        <= 1'b1;
                        cnt         <= CntW'(StrobeWidth - 1);
                        FrameStrobe <= MaxFramesPerCol'(1) << frameField;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        FrameStrobe <= '0;
                        if (GapCycles > 0) begin
                            state <= GAP;
                            cnt   <= CntW'(GapCycles - 1);
                        end else begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    Busy        <= 1'b0;
                    FrameStrobe <= '0;
                end
            endcase
        end
    end

endmodule
